slc3_mem_bridge: RTL and testbench
==================================

Name: slc3_mem_bridge

Overview:
- Memory/IO bridge between the SLC-3 CPU bus and the on-chip single-port RAM.
- Accepts one CPU request at a time and drives the RAM. Absorbs the RAM read latency and returns a ready pulse.
- Decodes the memory-mapped IO address: reads return the switches, writes load the hex-display register.
- Sits directly downstream of the CPU bus and upstream of the RAM.

Parameters:
- RAM_AW, 10, RAM address width; the RAM holds 2**RAM_AW words.
- RAM_LATENCY, 1, cycles from ram_rden-with-address to valid ram_q. Legal values 1..3.
- IO_ADDR, 16'hFFFF, CPU address decoded as the switch/hex IO port.

Ports:
- Clk  in  1  system clock, rising edge
- Reset_al  in  1  asynchronous active-low reset
- cpu_req  in  1  request strobe, one cycle; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data; held until the next read completes
- cpu_ready  out  1  one-cycle completion pulse
- busy  out  1  high in every state other than IDLE
- ram_addr  out  RAM_AW  RAM address
- ram_data  out  16  RAM write data
- ram_rden  out  1  RAM read enable
- ram_wren  out  1  RAM write enable
- ram_q  in  16  RAM read data
- SW  in  10  raw switches; asynchronous to Clk
- hex_data  out  16  hex-display register

Behaviour:
- Reset (asynchronous, Reset_al = 0):
  - state = IDLE.
  - cpu_rdata, hex_data, ram_addr, ram_data = 0.
  - cpu_ready, busy, ram_rden, ram_wren = 0.
  - Switch synchronizer flops = 0.
  - Reset asserted mid-operation aborts the access immediately: no ready pulse, no write, and no retry after reset is released.
- SW passes through a 2-flop synchronizer. IO reads return {6'b0, SW_sync}.
- Address decode, on the registered address:
  - IO: addr == IO_ADDR.
  - RAM: addr[15:RAM_AW] == 0.
  - Otherwise UNMAPPED.
- States: IDLE, RAM_RD, RAM_WR, DONE.
- IDLE, cpu_req = 1:
  - Register cpu_addr, cpu_wdata and cpu_we.
  - RAM read -> RAM_RD; RAM write -> RAM_WR.
  - IO or UNMAPPED access -> DONE.
  - In the same edge:
    - IO write: hex_data <= cpu_wdata.
    - IO read: cpu_rdata <= {6'b0, SW_sync}.
    - UNMAPPED read: cpu_rdata <= 16'h0000.
    - UNMAPPED write: dropped.
- RAM_RD:
  - ram_rden = 1 and ram_addr = addr[RAM_AW-1:0] on every cycle of the state.
  - A down-counter loaded with RAM_LATENCY runs in this state.
  - When the counter reaches 0: cpu_rdata <= ram_q, then -> DONE.
  - The state lasts exactly RAM_LATENCY+1 cycles.
- RAM_WR: ram_wren = 1 for exactly one cycle with ram_addr and ram_data, then -> DONE.
- DONE: cpu_ready = 1 for exactly one cycle, then -> IDLE.
- Latency, with the request sampled at edge k:
  - IO/UNMAPPED access: ready in cycle k+1.
  - RAM write: ready in cycle k+2.
  - RAM read: ready in cycle k+2+RAM_LATENCY.
- cpu_req while busy = 1 is ignored; no queuing.
- ram_rden and ram_wren are never both high. Both are 0 in IDLE and DONE.
- cpu_rdata changes only on read completion. hex_data changes only on an IO write.
- Address wrap: only the 0..2**RAM_AW-1 window maps to RAM. 16'h0400 (RAM_AW = 10) is UNMAPPED, not aliased to 0.

Test Plan:
- Reset with Reset_al = 0 mid-RAM_RD at cycle k+1 -> no cpu_ready pulse; all outputs 0; state IDLE; a new request after release completes normally.
- RAM write addr 16'h0005, data 16'hBEEF, then RAM read addr 16'h0005 with RAM_LATENCY = 1 -> ram_wren pulses once at k+1; read cpu_ready at k+3 with cpu_rdata = 16'hBEEF.
- SW = 10'h2A5, wait 2 cycles, read 16'hFFFF -> cpu_ready at k+1, cpu_rdata = 16'h02A5; ram_rden stays 0.
- Write 16'h1234 to 16'hFFFF -> hex_data = 16'h1234 after edge k; ram_wren stays 0; cpu_ready at k+1.
- Read 16'h0400, then write 16'hAAAA to 16'h0400 -> read returns 16'h0000; RAM word 0 is unchanged (verify by reading address 0).
- Second cpu_req asserted during RAM_RD with RAM_LATENCY = 3 -> ignored; exactly one cpu_ready pulse, at k+5; no RAM activity from the second request.

Source files
------------

// File: rtl/slc3_mem_bridge.sv
// SLC-3 CPU bus to single-port RAM bridge with a memory-mapped switch/hex IO port.
// Handles one access at a time, absorbs the RAM read latency and returns a one-cycle ready.
module slc3_mem_bridge #(
  parameter int          RAM_AW      = 10,
  parameter int          RAM_LATENCY = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset_al,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              busy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [15:0]       ram_q,
  input  logic [9:0]        SW,
  output logic [15:0]       hex_data
);

  typedef enum logic [1:0] {IDLE, RAM_RD, RAM_WR, DONE} state_t;

  state_t      state;
  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync;
  logic [1:0]  lat_cnt;
  logic        is_io;
  logic        is_ram;

  // IO takes priority so the IO port can never be shadowed by the RAM window.
  assign is_io  = (cpu_addr == IO_ADDR);
  assign is_ram = !is_io && (cpu_addr[15:RAM_AW] == '0);

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      busy      <= 1'b0;
      hex_data  <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_rden  <= 1'b0;
      ram_wren  <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            busy <= 1'b1;
            if (is_ram) begin
              ram_addr <= cpu_addr[RAM_AW-1:0];
              if (cpu_we) begin
                ram_data <= cpu_wdata;
                ram_wren <= 1'b1;
                state    <= RAM_WR;
              end else begin
                ram_rden <= 1'b1;
                lat_cnt  <= 2'(RAM_LATENCY);
                state    <= RAM_RD;
              end
            end else begin
              // IO and unmapped accesses finish on this edge; unmapped writes are dropped.
              if (cpu_we) begin
                if (is_io)
                  hex_data <= cpu_wdata;
              end else begin
                cpu_rdata <= is_io ? {6'b0, sw_sync} : 16'h0000;
              end
              cpu_ready <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RAM_RD: begin
          if (lat_cnt == 2'd0) begin
            cpu_rdata <= ram_q;
            ram_rden  <= 1'b0;
            cpu_ready <= 1'b1;
            state     <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RAM_WR: begin
          ram_wren  <= 1'b0;
          cpu_ready <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          ram_rden <= 1'b0;
          ram_wren <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Bench for slc3_mem_bridge: two instances (read latency 1 and 3) share one CPU stimulus,
// each backed by its own RAM model, and are checked against a word-level reference model.
module tb_slc3_mem_bridge;

  logic        Clk = 1'b0;
  logic        Reset_al;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [9:0]  SW;

  logic [15:0] rdata_a, rdata_b, hex_a, hex_b, ram_data_a, ram_data_b, q_a, q_b;
  logic [9:0]  ram_addr_a, ram_addr_b;
  logic        ready_a, ready_b, busy_a, busy_b, rden_a, rden_b, wren_a, wren_b;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ref_mem [0:1023];
  logic [15:0] ref_rdata;
  logic [15:0] ref_hex;

  always #5 Clk = ~Clk;

  slc3_mem_bridge #(.RAM_AW(10), .RAM_LATENCY(1), .IO_ADDR(16'hFFFF)) dut_a (
    .Clk(Clk), .Reset_al(Reset_al), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_a), .cpu_ready(ready_a),
    .busy(busy_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a), .ram_rden(rden_a),
    .ram_wren(wren_a), .ram_q(q_a), .SW(SW), .hex_data(hex_a)
  );

  slc3_mem_bridge #(.RAM_AW(10), .RAM_LATENCY(3), .IO_ADDR(16'hFFFF)) dut_b (
    .Clk(Clk), .Reset_al(Reset_al), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_b), .cpu_ready(ready_b),
    .busy(busy_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_rden(rden_b),
    .ram_wren(wren_b), .ram_q(q_b), .SW(SW), .hex_data(hex_b)
  );

  // Single-port RAM models: latency 1 for dut_a, a three-stage read pipe for dut_b.
  logic [15:0] mem_a [0:1023] = '{default: 16'h0000};
  logic [15:0] mem_b [0:1023] = '{default: 16'h0000};
  logic [15:0] pipe_b1, pipe_b2;

  always @(posedge Clk) begin
    if (wren_a) mem_a[ram_addr_a] <= ram_data_a;
    if (rden_a) q_a <= mem_a[ram_addr_a];
  end

  always @(posedge Clk) begin
    if (wren_b) mem_b[ram_addr_b] <= ram_data_b;
    if (rden_b) pipe_b1 <= mem_b[ram_addr_b];
    pipe_b2 <= pipe_b1;
    q_b     <= pipe_b2;
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_rdata_a", rdata_a, 16'h0000);
    checkOutput("rst_hex_a", hex_a, 16'h0000);
    checkOutput("rst_ramaddr_a", 16'(ram_addr_a), 16'h0000);
    checkOutput("rst_ramdata_a", ram_data_a, 16'h0000);
    checkOutput("rst_ctl_a", 16'({ready_a, busy_a, rden_a, wren_a}), 16'h0000);
    checkOutput("rst_rdata_b", rdata_b, 16'h0000);
    checkOutput("rst_hex_b", hex_b, 16'h0000);
    checkOutput("rst_ramaddr_b", 16'(ram_addr_b), 16'h0000);
    checkOutput("rst_ramdata_b", ram_data_b, 16'h0000);
    checkOutput("rst_ctl_b", 16'({ready_b, busy_b, rden_b, wren_b}), 16'h0000);
  endtask

  // One CPU access. inj > 0 pulses a stray write request in that cycle after the accepted one.
  task automatic applyStimulus(input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input int inj);
    logic io, ram;
    int lat_a, lat_b, rd_a, rd_b, wr_exp;
    int first_a = 0, first_b = 0, nrdy_a = 0, nrdy_b = 0;
    int nrd_a = 0, nrd_b = 0, nwr_a = 0, nwr_b = 0, bad = 0;
    logic busy1_a = 1'b0, busy1_b = 1'b0;

    io     = (addr == 16'hFFFF);
    ram    = !io && (addr[15:10] == 6'd0);
    lat_a  = !ram ? 1 : (we ? 2 : 2 + 1);
    lat_b  = !ram ? 1 : (we ? 2 : 2 + 3);
    rd_a   = (ram && !we) ? 1 + 1 : 0;
    rd_b   = (ram && !we) ? 3 + 1 : 0;
    wr_exp = (ram && we) ? 1 : 0;

    if (we) begin
      if (io) ref_hex = wdata;
      else if (ram) ref_mem[addr[9:0]] = wdata;
    end else begin
      ref_rdata = io ? {6'b0, SW} : (ram ? ref_mem[addr[9:0]] : 16'h0000);
    end

    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge Clk);
    cpu_req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (n == 1) begin busy1_a = busy_a; busy1_b = busy_b; end
      if (ready_a) begin nrdy_a++; if (first_a == 0) first_a = n; end
      if (ready_b) begin nrdy_b++; if (first_b == 0) first_b = n; end
      if (rden_a) nrd_a++;
      if (rden_b) nrd_b++;
      if (wren_a) nwr_a++;
      if (wren_b) nwr_b++;
      if ((rden_a || wren_a) && ram_addr_a !== addr[9:0]) bad++;
      if ((rden_b || wren_b) && ram_addr_b !== addr[9:0]) bad++;
      if (wren_a && ram_data_a !== wdata) bad++;
      if (wren_b && ram_data_b !== wdata) bad++;
      if ((rden_a && wren_a) || (rden_b && wren_b)) bad++;
      if (n == inj) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0007; cpu_wdata = 16'h5555;
      end else begin
        cpu_req = 1'b0;
      end
      @(negedge Clk);
    end
    cpu_req = 1'b0;

    checkOutput("busy_a", 16'(busy1_a), 16'h0001);
    checkOutput("busy_b", 16'(busy1_b), 16'h0001);
    checkOutput("latency_a", 16'(first_a), 16'(lat_a));
    checkOutput("latency_b", 16'(first_b), 16'(lat_b));
    checkOutput("ready_pulses_a", 16'(nrdy_a), 16'h0001);
    checkOutput("ready_pulses_b", 16'(nrdy_b), 16'h0001);
    checkOutput("rden_cycles_a", 16'(nrd_a), 16'(rd_a));
    checkOutput("rden_cycles_b", 16'(nrd_b), 16'(rd_b));
    checkOutput("wren_cycles_a", 16'(nwr_a), 16'(wr_exp));
    checkOutput("wren_cycles_b", 16'(nwr_b), 16'(wr_exp));
    checkOutput("ram_bus_errors", 16'(bad), 16'h0000);
    checkOutput("rdata_a", rdata_a, ref_rdata);
    checkOutput("rdata_b", rdata_b, ref_rdata);
    checkOutput("hex_a", hex_a, ref_hex);
    checkOutput("hex_b", hex_b, ref_hex);
  endtask

  initial begin
    int nrdy;
    logic [15:0] a;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
    ref_rdata = 16'h0000;
    ref_hex   = 16'h0000;
    Reset_al = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0000; cpu_wdata = 16'h0000; SW = 10'h000;
    repeat (2) @(negedge Clk);
    checkResetState();
    Reset_al = 1'b1;
    repeat (2) @(negedge Clk);

    applyStimulus(1'b1, 16'h0005, 16'hBEEF, 0);
    applyStimulus(1'b0, 16'h0005, 16'h0000, 0);

    SW = 10'h2A5;
    repeat (3) @(negedge Clk);
    applyStimulus(1'b0, 16'hFFFF, 16'h0000, 0);
    applyStimulus(1'b1, 16'hFFFF, 16'h1234, 0);

    applyStimulus(1'b0, 16'h0400, 16'h0000, 0);
    applyStimulus(1'b1, 16'h0400, 16'hAAAA, 0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 0);

    applyStimulus(1'b0, 16'h0005, 16'h0000, 2);
    applyStimulus(1'b0, 16'h0007, 16'h0000, 0);

    // Reset in the first RAM_RD cycle: the access must vanish without a ready pulse.
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    @(negedge Clk);
    cpu_req = 1'b0;
    Reset_al = 1'b0;
    #1;
    checkResetState();
    ref_rdata = 16'h0000;
    ref_hex   = 16'h0000;
    @(negedge Clk);
    Reset_al = 1'b1;
    nrdy = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge Clk);
      if (ready_a || ready_b || busy_a || busy_b) nrdy++;
    end
    checkOutput("activity_after_reset", 16'(nrdy), 16'h0000);
    repeat (3) @(negedge Clk);
    applyStimulus(1'b0, 16'h0005, 16'h0000, 0);
    applyStimulus(1'b1, 16'h0009, 16'h0C3C, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        SW = 10'($urandom);
        repeat (3) @(negedge Clk);
      end
      case ($urandom_range(0, 3))
        0:       a = {12'h000, 4'($urandom)};
        1:       a = {6'b0, 10'($urandom)};
        2:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      applyStimulus(1'($urandom_range(0, 1)), a, 16'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
